// File: rtl/jtframe_mister_pkg.sv
// Shared constants and types for the MiSTer download-to-SDRAM programming stage.
package jtframe_mister_pkg;

    // A bank start at the top of the address space marks that bank as not present
    localparam logic [26:0] UNUSED_BANK   = 27'h7FF_FFFF;
    localparam logic [26:0] DEF_BA1_START = 27'h040_0000;
    localparam logic [26:0] DEF_BA2_START = UNUSED_BANK;
    localparam logic [26:0] DEF_BA3_START = UNUSED_BANK;

    // One buffered SDRAM write: bank, word address, byte value, active-low byte mask
    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } prog_entry_t;

    localparam int ENTRY_W = $bits(prog_entry_t);

    // Even byte offsets land in the low byte of the 16-bit word
    function automatic logic [1:0] byte_mask(input logic odd);
        return odd ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO holding resolved SDRAM writes between the
// address-mapping stage and the issue FSM.
module jtframe_prog_fifo #(
    parameter int W  = 34,
    parameter int AW = 2
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A pop on empty is ignored; a push on full only lands if a pop frees a slot
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jtframe_mister_prog.sv
// Downstream stage of the MiSTer download path: strips the ROM header, maps
// each byte to an SDRAM bank/word/mask, buffers it and issues held writes.
module jtframe_mister_prog
    import jtframe_mister_pkg::*;
#(
    parameter logic [26:0] HEADER    = 27'd0,
    parameter logic [26:0] BA1_START = DEF_BA1_START,
    parameter logic [26:0] BA2_START = DEF_BA2_START,
    parameter logic [26:0] BA3_START = DEF_BA3_START,
    parameter int          FIFO_AW   = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        ioctl_rom_wr,
    input  logic        ioctl_ram,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_rdy,
    output logic        dwnld_busy,
    output logic        overflow,
    output logic        prog_we,
    input  logic        prog_ack,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam bit BA2_USED = (BA2_START != UNUSED_BANK);
    localparam bit BA3_USED = (BA3_START != UNUSED_BANK);

    logic        stage_full;
    logic        stage_ram;
    logic [26:0] stage_addr;
    logic [7:0]  stage_data;

    logic [27:0] hdr_diff;
    logic [26:0] eff;
    logic [1:0]  bank;
    logic [22:0] bank_base;
    logic [22:0] off;
    logic        drop;
    logic        drain;
    logic        push;
    logic        pop;

    prog_entry_t entry_in;
    prog_entry_t entry_out;
    logic        fifo_full;
    logic        fifo_empty;

    logic [0:0]  state;
    logic        dl_last;
    logic        dl_rise;
    logic        all_idle;

    // The extra top bit of the subtraction is the borrow: set when addr < HEADER
    assign hdr_diff = {1'b0, stage_addr} - {1'b0, HEADER};
    assign eff      = hdr_diff[26:0];
    assign drop     = stage_ram || hdr_diff[27];

    // Stage empties either by dropping the byte or by pushing it into the FIFO
    assign drain     = stage_full && (drop || !fifo_full);
    assign push      = stage_full && !drop && !fifo_full;
    assign ioctl_rdy = drain;

    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign dl_rise  = downloading && !dl_last;
    assign all_idle = !stage_full && fifo_empty && (state == ST_IDLE) && !prog_we;

    // Bank selection from the highest bank down, then the in-bank word/mask.
    // Only the low 23 offset bits reach the bus, so the subtraction is done at that width.
    always_comb begin
        bank      = 2'd0;
        bank_base = '0;
        if (BA3_USED && eff >= BA3_START) begin
            bank      = 2'd3;
            bank_base = BA3_START[22:0];
        end else if (BA2_USED && eff >= BA2_START) begin
            bank      = 2'd2;
            bank_base = BA2_START[22:0];
        end else if (eff >= BA1_START) begin
            bank      = 2'd1;
            bank_base = BA1_START[22:0];
        end
        off           = eff[22:0] - bank_base;
        entry_in.ba   = bank;
        entry_in.addr = off[22:1];
        entry_in.data = stage_data;
        entry_in.mask = byte_mask(off[0]);
    end

    // Capture stage: accept a strobe when empty or when the held byte leaves this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_full <= 1'b0;
            stage_ram  <= 1'b0;
            stage_addr <= '0;
            stage_data <= '0;
        end else if (ioctl_rom_wr && (!stage_full || drain)) begin
            stage_full <= 1'b1;
            stage_ram  <= ioctl_ram;
            stage_addr <= ioctl_addr;
            stage_data <= ioctl_dout;
        end else if (drain) begin
            stage_full <= 1'b0;
        end
    end

    jtframe_prog_fifo #(
        .W  (ENTRY_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (entry_in),
        .pop   (pop),
        .dout  (entry_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue FSM: load one entry onto the bus and hold it until the controller acks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
            prog_ba   <= '0;
        end else if (state == ST_IDLE) begin
            if (pop) begin
                prog_addr <= entry_out.addr;
                prog_data <= {entry_out.data, entry_out.data};
                prog_mask <= entry_out.mask;
                prog_ba   <= entry_out.ba;
                prog_we   <= 1'b1;
                state     <= ST_WAIT;
            end
        end else if (prog_ack) begin
            prog_we <= 1'b0;
            state   <= ST_IDLE;
        end
    end

    // Status flags: busy spans the download window plus the drain; a lost write
    // is sticky until the next download starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_last    <= 1'b0;
            overflow   <= 1'b0;
            dwnld_busy <= 1'b0;
        end else begin
            dl_last <= downloading;
            if (ioctl_rom_wr && stage_full && !drain) overflow <= 1'b1;
            else if (dl_rise)                         overflow <= 1'b0;
            if (dl_rise)                       dwnld_busy <= 1'b1;
            else if (!downloading && all_idle) dwnld_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtframe_mister_prog.sv
// Self-checking bench for jtframe_mister_prog: directed scenarios plus a
// randomized stream checked against a byte-to-SDRAM mapping model.
module tb_jtframe_mister_prog;
    import jtframe_mister_pkg::*;

    localparam logic [26:0] BA1   = 27'h040_0000;
    localparam logic [26:0] BA2   = 27'h100_0000;
    localparam logic [26:0] BA3   = UNUSED_BANK;
    localparam logic [26:0] HDR_H = 27'h40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic        wr = 1'b0;
    logic        ram = 1'b0;
    logic [26:0] addr = '0;
    logic [7:0]  din = '0;

    logic        rdy, busy, ovf, we;
    logic        ack = 1'b0;
    logic [21:0] paddr;
    logic [15:0] pdata;
    logic [1:0]  pmask, pba;

    logic        h_rdy, h_busy, h_ovf, h_we;
    logic        h_ack = 1'b0;
    logic [21:0] h_addr;
    logic [15:0] h_data;
    logic [1:0]  h_mask, h_ba;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtframe_mister_prog #(.HEADER(27'd0), .BA1_START(BA1), .BA2_START(BA2),
                          .BA3_START(BA3), .FIFO_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_rom_wr(wr), .ioctl_ram(ram), .ioctl_addr(addr), .ioctl_dout(din),
        .ioctl_rdy(rdy), .dwnld_busy(busy), .overflow(ovf),
        .prog_we(we), .prog_ack(ack), .prog_addr(paddr), .prog_data(pdata),
        .prog_mask(pmask), .prog_ba(pba)
    );

    jtframe_mister_prog #(.HEADER(HDR_H), .BA1_START(BA1), .BA2_START(BA2),
                          .BA3_START(BA3), .FIFO_AW(2)) dut_h (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_rom_wr(wr), .ioctl_ram(ram), .ioctl_addr(addr), .ioctl_dout(din),
        .ioctl_rdy(h_rdy), .dwnld_busy(h_busy), .overflow(h_ovf),
        .prog_we(h_we), .prog_ack(h_ack), .prog_addr(h_addr), .prog_data(h_data),
        .prog_mask(h_mask), .prog_ba(h_ba)
    );

    // Observed writes / expected writes, packed {ba, addr, data16, mask}
    logic [41:0] obs_q[$];
    logic [41:0] exp_q[$];
    logic [41:0] h_q[$];
    int   rdy_cnt = 0;
    int   ack_cnt = 0;
    int   rsp_cnt = 0;
    int   h_rsp = 0;
    logic we_d = 1'b0;
    logic h_we_d = 1'b0;
    logic ack_en = 1'b1;
    logic last_rdy, last_h_rdy;

    // Main DUT: record each new request, count accept pulses, ack 2 cycles after we
    always @(negedge clk) begin
        if (!rst_n) begin
            ack = 1'b0; rsp_cnt = 0; we_d = 1'b0;
        end else begin
            if (rdy) rdy_cnt++;
            if (we && !we_d) obs_q.push_back({pba, paddr, pdata, pmask});
            we_d = we;
            ack  = 1'b0;
            if (we && ack_en) begin
                rsp_cnt++;
                if (rsp_cnt == 2) begin ack = 1'b1; rsp_cnt = 0; ack_cnt++; end
            end else rsp_cnt = 0;
        end
    end

    // Header DUT: same recording, always acks
    always @(negedge clk) begin
        if (!rst_n) begin
            h_ack = 1'b0; h_rsp = 0; h_we_d = 1'b0;
        end else begin
            if (h_we && !h_we_d) h_q.push_back({h_ba, h_addr, h_data, h_mask});
            h_we_d = h_we;
            h_ack  = 1'b0;
            if (h_we) begin
                h_rsp++;
                if (h_rsp == 2) begin h_ack = 1'b1; h_rsp = 0; end
            end else h_rsp = 0;
        end
    end

    // Reference: what a byte should become on the SDRAM bus; bit 42 = a write happens
    function automatic logic [42:0] ref_map(input logic [26:0] a, input logic [7:0] d,
                                            input logic r, input logic [26:0] hdr);
        logic [26:0] e;
        logic [26:0] base;
        logic [1:0]  b;
        if (r || a < hdr) return '0;
        e = a - hdr;
        if (BA3 != UNUSED_BANK && e >= BA3)      begin b = 2'd3; base = BA3; end
        else if (BA2 != UNUSED_BANK && e >= BA2) begin b = 2'd2; base = BA2; end
        else if (e >= BA1)                       begin b = 2'd1; base = BA1; end
        else                                     begin b = 2'd0; base = '0;  end
        e = e - base;
        return {1'b1, b, e[22:1], d, d, (e[0] ? 2'b01 : 2'b10)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // One-cycle strobe; accept pulse is sampled one cycle after the strobe
    task automatic send(input logic [26:0] a, input logic [7:0] d, input logic r, input bit model);
        logic [42:0] m;
        @(negedge clk);
        wr = 1'b1; addr = a; din = d; ram = r;
        @(negedge clk);
        wr = 1'b0;
        last_rdy   = rdy;
        last_h_rdy = h_rdy;
        if (model) begin
            m = ref_map(a, d, r, 27'd0);
            if (m[42]) exp_q.push_back(m[41:0]);
        end
    endtask

    // Wait for every expected write since the bases, then compare in order
    task automatic check_writes(input int ob, input int eb, input string tag);
        int n;
        int t;
        n = exp_q.size() - eb;
        t = 0;
        while (obs_q.size() - ob < n && t < 1000) begin @(negedge clk); t++; end
        chk({tag, "_count"}, obs_q.size() - ob, n);
        for (int i = 0; i < n && ob + i < obs_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), obs_q[ob+i], exp_q[eb+i]);
        tick(4);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ob, eb, rb, hb, ab, t;
        logic [42:0] m;
        logic [26:0] a;

        // Reset state
        tick(3);
        chk("rst_we", we, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_bus", {paddr, pdata, pmask, pba}, 0);
        rst_n = 1'b1;
        tick(2);

        // 1: two bytes of one word
        ob = obs_q.size(); eb = exp_q.size();
        send(27'h0, 8'hAA, 1'b0, 1'b1);
        chk("t1_rdy0", last_rdy, 1);
        send(27'h1, 8'h55, 1'b0, 1'b1);
        chk("t1_rdy1", last_rdy, 1);
        check_writes(ob, eb, "t1");
        chk("t1_lo", obs_q[ob], {2'd0, 22'd0, 16'hAAAA, 2'b10});
        chk("t1_hi", obs_q[ob+1], {2'd0, 22'd0, 16'h5555, 2'b01});

        // 2: header stripping on the HEADER=0x40 instance
        do_reset();
        hb = h_q.size();
        send(27'h3F, 8'h11, 1'b0, 1'b0);
        chk("t2_drop_rdy", last_h_rdy, 1);
        tick(6);
        chk("t2_drop_nowrite", h_q.size(), hb);
        send(27'h40, 8'h22, 1'b0, 1'b0);
        chk("t2_rdy", last_h_rdy, 1);
        t = 0;
        while (h_q.size() == hb && t < 100) begin @(negedge clk); t++; end
        chk("t2_wrote", h_q.size(), hb + 1);
        m = ref_map(27'h40, 8'h22, 1'b0, HDR_H);
        chk("t2_write", h_q[hb], m[41:0]);
        chk("t2_ba_addr", h_q[hb][41:18], 0);

        // 3: bank 0 / bank 1 boundary
        do_reset();
        ob = obs_q.size(); eb = exp_q.size();
        send(27'h03F_FFFF, 8'h5A, 1'b0, 1'b1);
        send(27'h040_0000, 8'hA5, 1'b0, 1'b1);
        check_writes(ob, eb, "t3");
        chk("t3_last_ba0", obs_q[ob], {2'd0, 22'h1F_FFFF, 16'h5A5A, 2'b01});
        chk("t3_first_ba1", obs_q[ob+1], {2'd1, 22'd0, 16'hA5A5, 2'b10});

        // 4: backpressure with acks withheld
        do_reset();
        ack_en = 1'b0;
        ob = obs_q.size(); eb = exp_q.size(); rb = rdy_cnt;
        for (int i = 0; i < 6; i++) send(27'h100 + 27'(i), 8'h10 + 8'(i), 1'b0, 1'b1);
        tick(4);
        chk("t4_rdy5", rdy_cnt - rb, 5);
        chk("t4_inflight", obs_q.size() - ob, 1);
        chk("t4_we_held", we, 1);
        chk("t4_ovf_clear", ovf, 0);
        send(27'h106, 8'h77, 1'b0, 1'b0);
        chk("t4_ovf_set", ovf, 1);
        ack_en = 1'b1;
        check_writes(ob, eb, "t4");
        chk("t4_rdy6", rdy_cnt - rb, 6);

        // 5: busy across the drain; new download clears overflow
        chk("t5_ovf_before", ovf, 1);
        downloading = 1'b1;
        tick(2);
        chk("t5_ovf_clr", ovf, 0);
        chk("t5_busy_set", busy, 1);
        ack_en = 1'b0;
        ob = obs_q.size(); eb = exp_q.size();
        for (int i = 0; i < 3; i++) send(27'h300 + 27'(i), 8'hC0 + 8'(i), 1'b0, 1'b1);
        tick(2);
        downloading = 1'b0;
        tick(5);
        chk("t5_busy_hold", busy, 1);
        ab = ack_cnt;
        ack_en = 1'b1;
        t = 0;
        while (ack_cnt - ab < 3 && t < 200) begin @(posedge clk); t++; end
        chk("t5_acks", ack_cnt - ab, 3);
        #1;
        chk("t5_we_done", we, 0);
        chk("t5_busy_at_ack", busy, 1);
        @(posedge clk); #1;
        chk("t5_busy_fall", busy, 0);
        check_writes(ob, eb, "t5");

        // 6: reset while a write is held
        do_reset();
        downloading = 1'b1;
        tick(2);
        ack_en = 1'b0;
        send(27'h200, 8'h01, 1'b0, 1'b0);
        send(27'h201, 8'h02, 1'b0, 1'b0);
        tick(3);
        chk("t6_we_pre", we, 1);
        chk("t6_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_we", we, 0);
        chk("t6_rdy", rdy, 0);
        chk("t6_busy", busy, 0);
        downloading = 1'b0;
        ack_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        ob = obs_q.size();
        tick(8);
        chk("t6_no_write", obs_q.size(), ob);
        chk("t6_we_post", we, 0);

        // 7: randomized stream at a rate the issue side can sustain
        do_reset();
        ob = obs_q.size(); eb = exp_q.size(); rb = rdy_cnt;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3))
                0: a = BA1 - 27'd16 + 27'($urandom_range(31));
                1: a = BA2 - 27'd16 + 27'($urandom_range(31));
                2: a = 27'($urandom);
                default: a = 27'($urandom_range(255));
            endcase
            send(a, 8'($urandom), ($urandom_range(7) == 0), 1'b1);
            tick($urandom_range(4, 2));
        end
        check_writes(ob, eb, "t7");
        chk("t7_rdy", rdy_cnt - rb, 40);
        chk("t7_ovf", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
